// File: rtl/sram1_lsu.sv
// Load/store initiator for the word-wide sram1 port: range checks, lane extraction
// and read-modify-write for sub-word stores. Optional macro: SRAM1_LSU_MISALIGN_TRAP_EN.
module sram1_lsu #(
    parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
    parameter logic [31:0] SIZE_BYTES     = 32'h0001_8000,
    parameter int unsigned MEM_RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 2;
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES} - 33'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        lane, lane_n;
    logic [1:0]        size, size_n;
    logic              sgn, sgn_n;
    logic [31:0]       wdata, wdata_n;
    logic              req_ready_n, resp_valid_n, resp_fault_n, mem_read_write_n;
    logic [31:0]       resp_rdata_n, mem_address_n, mem_wdata_n;
    logic              req_fault_c;
    logic [32:0]       last_c;

    // Pick the addressed lane out of a memory word and extend it.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic s);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return s ? {{24{b[7]}}, b} : {24'd0, b};
            2'd1:    return s ? {{16{h[15]}}, h} : {16'd0, h};
            default: return w;
        endcase
    endfunction

    // Replace the addressed lane of a memory word with right-aligned store data.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) begin
            case (a)
                2'd0:    return {w[31:8], d[7:0]};
                2'd1:    return {w[31:16], d[7:0], w[7:0]};
                2'd2:    return {w[31:24], d[7:0], w[15:0]};
                default: return {d[7:0], w[23:0]};
            endcase
        end else if (sz == 2'd1) begin
            return a[1] ? {d[15:0], w[15:0]} : {w[31:16], d[15:0]};
        end
        return d;
    endfunction

    // Fault decision on the incoming request; range compare in 33 bits avoids wrap.
    always_comb begin
        last_c      = {1'b0, req_addr};
        req_fault_c = 1'b0;
        case (req_size)
            2'd0:    last_c = {1'b0, req_addr};
            2'd1:    last_c = {1'b0, req_addr} + 33'd1;
            default: last_c = {1'b0, req_addr} + 33'd3;
        endcase
        if ({1'b0, req_addr} < WIN_LO || last_c > WIN_HI || req_size == 2'd3)
            req_fault_c = 1'b1;
`ifdef SRAM1_LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0))
            req_fault_c = 1'b1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lane           <= 2'd0;
            size           <= 2'd0;
            sgn            <= 1'b0;
            wdata          <= 32'd0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'd0;
            resp_fault     <= 1'b0;
            mem_read_write <= 1'b0;
            mem_address    <= BASE_ADDR;
            mem_wdata      <= 32'd0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            lane           <= lane_n;
            size           <= size_n;
            sgn            <= sgn_n;
            wdata          <= wdata_n;
            req_ready      <= req_ready_n;
            resp_valid     <= resp_valid_n;
            resp_rdata     <= resp_rdata_n;
            resp_fault     <= resp_fault_n;
            mem_read_write <= mem_read_write_n;
            mem_address    <= mem_address_n;
            mem_wdata      <= mem_wdata_n;
        end
    end

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        lane_n           = lane;
        size_n           = size;
        sgn_n            = sgn;
        wdata_n          = wdata;
        resp_valid_n     = resp_valid;
        resp_rdata_n     = resp_rdata;
        resp_fault_n     = resp_fault;
        mem_read_write_n = 1'b0;
        mem_address_n    = mem_address;
        mem_wdata_n      = mem_wdata;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    lane_n        = req_addr[1:0];
                    size_n        = req_size;
                    sgn_n         = req_signed;
                    wdata_n       = req_wdata;
                    cnt_n         = '0;
                    mem_address_n = {req_addr[31:2], 2'b00};
                    if (req_fault_c) begin
                        state_n       = S_RESP;
                        resp_valid_n  = 1'b1;
                        resp_fault_n  = 1'b1;
                        resp_rdata_n  = 32'd0;
                        mem_address_n = mem_address;
                    end else if (!req_write) begin
                        state_n = S_RD;
                    end else if (req_size == 2'd2) begin
                        state_n          = S_WR;
                        mem_wdata_n      = req_wdata;
                        mem_read_write_n = 1'b1;
                    end else begin
                        state_n = S_RMW_RD;
                    end
                end
            end
            S_RD, S_RMW_RD: begin
                if (cnt == CNT_LAST) begin
                    if (state == S_RD) begin
                        state_n      = S_RESP;
                        resp_valid_n = 1'b1;
                        resp_fault_n = 1'b0;
                        resp_rdata_n = extract(mem_rdata, lane, size, sgn);
                    end else begin
                        state_n          = S_WR;
                        mem_wdata_n      = merge(mem_rdata, lane, size, wdata);
                        mem_read_write_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WR: begin
                state_n      = S_RESP;
                resp_valid_n = 1'b1;
                resp_fault_n = 1'b0;
                resp_rdata_n = 32'd0;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_n      = S_IDLE;
                    resp_valid_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
        req_ready_n = (state_n == S_IDLE);
    end

endmodule

// File: doc/sram1_lsu.md
Name: sram1_lsu

Overview:
- Load/store initiator that drives the sram1 memory port on behalf of the core.
- Accepts byte, halfword and word requests over a valid/ready handshake.
- Range-checks each address against the sram1 window. Converts sub-word stores into a read-modify-write, because sram1 is word-wide with no byte enables.
- Returns zero- or sign-extended load data with a fault flag.

Parameters:
- BASE_ADDR, 32'h20000000, first byte address of the sram1 window.
- SIZE_BYTES, 32'h00018000, window size in bytes; the last valid byte is BASE_ADDR+SIZE_BYTES-1.
- MEM_RD_LATENCY, 1, cycles from presenting a read address on the memory port to valid mem_rdata (1..4).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (faults).
- req_signed  in  1  sign-extend load data; ignored for word accesses and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  load data, extended; 0 for stores and faults.
- resp_fault  out  1  access rejected.
- mem_read_write  out  1  sram1 read_write: 1 = write this cycle.
- mem_address  out  32  sram1 address; always word-aligned, low 2 bits are 0.
- mem_wdata  out  32  to sram1 data_in.
- mem_rdata  in  32  from sram1 data_out.

Behaviour:
- Reset values: req_ready=0 while reset is asserted and 1 in IDLE after it; resp_valid=0; resp_rdata=0; resp_fault=0; mem_read_write=0; mem_address=BASE_ADDR; mem_wdata=0.
- Reset mid-operation: state forced to IDLE, any pending write is dropped (mem_read_write low immediately), no response is issued.
- Request fault (no memory access) when:
  - addr < BASE_ADDR, or
  - addr+bytes-1 > BASE_ADDR+SIZE_BYTES-1, or
  - req_size=3, or
  - the access is misaligned (see Optional Feature).
- The range comparison is done in 33 bits, so there is no wrap at 0xFFFFFFFF.
- Lanes are little-endian: byte lane = addr[1:0]; halfword lane = addr[1].
- States:
  - IDLE: req_ready=1. On req_valid, latch the request.
    - Fault -> RESP with fault=1.
    - Load -> RD.
    - Word store -> WR.
    - Sub-word store -> RMW_RD.
  - RD: drive mem_address = {addr[31:2],2'b00}, read_write=0. Wait MEM_RD_LATENCY cycles, capture mem_rdata, extract the lane and extend it, -> RESP.
  - RMW_RD: same as RD, then merge req_wdata into the selected lane of the captured word, -> WR.
  - WR: exactly one cycle with read_write=1, mem_address aligned, mem_wdata set -> RESP.
  - RESP: resp_valid=1, outputs stable until resp_ready. On resp_ready -> IDLE. A new request cannot be accepted in the same cycle; req_ready is low in RESP.
- Latency with MEM_RD_LATENCY=1:
  - Load: accept to resp_valid = 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Fault: 1 cycle.
- mem_read_write is 1 only in WR; there are never back-to-back writes without an intervening IDLE.
- resp_ready held high: one request completes every latency+1 cycles.

Optional Feature:
- Macro SRAM1_LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=0, faults (resp_fault=1, no memory access).
- Undefined: the offending low address bits are ignored. A halfword uses lane addr[1]; a word uses the aligned word. No fault is raised for misalignment.

Test Plan:
- Word store 0x01234567 @0x20000000, then word load @0x20000000 -> one write cycle with mem_address 0x20000000; load resp_rdata=0x01234567, fault=0, 2 cycles.
- Byte store 0xAB @0x20000002 over word 0x01234567 -> read then write of 0x01AB4567. Signed byte load @0x20000002 -> 0xFFFFFFAB. Unsigned byte load -> 0x000000AB.
- Word store @0x20018000 and load @0x1FFFFFFC -> resp_fault=1 after 1 cycle, mem_read_write never 1, resp_rdata=0.
- Word load @0x20017FFC -> accepted. Halfword load @0x20017FFF -> fault (spans the window end).
- Halfword load @0x20000001 on word 0x89ABCDEF:
  - With the macro: fault.
  - Without the macro: resp_rdata=0x0000CDEF (unsigned).
- Assert reset in RMW_RD of a byte store -> mem_read_write stays 0, no resp_valid; after release, req_ready=1 and memory is unchanged.
